div_seq_core: RTL
=================

Name: div_seq_core

Overview:
Sequential restoring divider core consumed by the divider peripheral. It takes the peripheral's registered dividend, divisor and level-style start bit. It produces a packed {remainder, quotient} word and a sticky done flag that the peripheral returns on bus reads. Radix-2 algorithm, one quotient bit per clock, unsigned operands only.

Parameters:
WIDTH, 16, operand width in bits; result bus is 2*WIDTH bits.

Ports:
clock  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
comenzar  input  1  start request; level signal held by the peripheral, only its 0->1 transition starts an operation
dividendo  input  WIDTH  unsigned dividend; sampled on the start edge only
divisor  input  WIDTH  unsigned divisor; sampled on the start edge only
cociente  output  2*WIDTH  result: [WIDTH-1:0] = quotient, [2*WIDTH-1:WIDTH] = remainder
finalizado  output  1  done flag; sticky high until the next accepted start

Behaviour:
- Reset (rst=1 at an edge):
  - state <= IDLE; cociente <= 0; finalizado <= 0.
  - comenzar_q (start-edge register) <= 0; iteration counter and working registers <= 0.
  - Reset wins over every other event, including mid-RUN: the operation is abandoned and there is no partial result.
- Start detect:
  - start_pulse = comenzar & ~comenzar_q; comenzar_q <= comenzar every non-reset cycle, in every state.
  - Because comenzar_q resets to 0, a comenzar held high across reset release produces one start pulse.
  - A level held high never restarts; a new operation requires comenzar to go low then high again.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start_pulse=1 (edge E0):
  - Latch dividendo and divisor into internal registers; finalizado <= 0; cociente holds its previous value.
  - If the divisor is 0, go to DIV0 handling (below). Otherwise state <= RUN, counter <= WIDTH, partial remainder <= 0 (WIDTH+1 bits), quotient shift register <= latched dividend.
- RUN, each edge:
  - trial = {rem[WIDTH-1:0], q_sr[WIDTH-1]} - {1'b0, divisor_r}.
  - If trial is non-negative (MSB = 0): rem <= trial; shift in quotient bit 1. Otherwise: rem <= shifted value; shift in quotient bit 0.
  - counter <= counter - 1.
- RUN, final iteration (counter = 1 at the edge, edge E_WIDTH):
  - cociente <= {final remainder[WIDTH-1:0], final quotient}, finalizado <= 1, and state <= DONE, all at the same edge.
  - Latency: finalizado first reads 1 exactly WIDTH cycles after E0 (16 for the default).
- DIV0 (divisor = 0 at E0):
  - State goes to DONE at E0.
  - At E1: cociente <= {dividend, all-ones quotient}, finalizado <= 1.
  - Latency is 1 cycle. Implemented as a one-cycle pending flag in DONE.
- start_pulse during RUN: ignored. The operation continues with the latched operands, and comenzar_q still tracks the input.
- Operand inputs changing during RUN: no effect.
- DONE: cociente and finalizado hold until an accepted start or reset.
- Arithmetic is unsigned, with no overflow possible: quotient is at most 2^WIDTH-1 and remainder is less than the divisor.

Test Plan:
- Reset, then dividendo=100, divisor=7, comenzar 0->1 -> finalizado=0 for 15 cycles after E0 and 1 at the 16th; cociente=0x0002000E.
- 65535/1 -> cociente=0x0000FFFF. 5/9 -> cociente=0x00050000. 65535/65535 -> cociente=0x00000001.
- Divide by zero, dividendo=1234, divisor=0 -> finalizado=1 one cycle after E0; cociente=0x04D2FFFF.
- Start 100/7, drop and re-raise comenzar and change operands to 9/3 at cycle 5 of RUN -> result still 0x0002000E at cycle 16. Then hold comenzar high -> no restart, finalizado stays 1. Then toggle comenzar 0->1 -> 9/3 gives 0x00000003.
- rst asserted at cycle 8 of RUN -> next cycle cociente=0, finalizado=0, state IDLE; release rst with comenzar still high -> one new operation starts.
- Back-to-back: after done, start 200/13 -> finalizado drops at E0, cociente holds 0x0002000E until E16, then reads 0x0005000F.

Source files
------------

// File: rtl/div_seq_core.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Packs {remainder, quotient} into cociente; finalizado is sticky until the next start.
module div_seq_core #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               comenzar,
    input  logic [WIDTH-1:0]   dividendo,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] cociente,
    output logic               finalizado
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic             comenzar_q;
    logic             start_pulse;
    logic             accept;
    logic             last;
    logic             div0_pend;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign start_pulse = comenzar & ~comenzar_q;
    assign accept      = start_pulse && (state != RUN);
    assign last        = (state == RUN) && (cnt == CW'(1));

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: keep the trial difference only when it did not borrow.
    always_comb begin
        trial   = {rem, q_sr[WIDTH-1]} - {1'b0, div_r};
        rem_nxt = trial[WIDTH] ? {rem[WIDTH-2:0], q_sr[WIDTH-1]} : trial[WIDTH-1:0];
        q_nxt   = {q_sr[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            comenzar_q <= 1'b0;
            cociente   <= '0;
            finalizado <= 1'b0;
            div0_pend  <= 1'b0;
            cnt        <= '0;
            rem        <= '0;
            q_sr       <= '0;
            div_r      <= '0;
        end else begin
            comenzar_q <= comenzar;
            if (accept) begin
                finalizado <= 1'b0;
                div_r      <= divisor;
                q_sr       <= dividendo;
                rem        <= '0;
                cnt        <= CW'(WIDTH);
                div0_pend  <= (divisor == '0);
            end else if (state == RUN) begin
                rem <= rem_nxt;
                q_sr <= q_nxt;
                cnt <= cnt - CW'(1);
                if (last) begin
                    cociente   <= {rem_nxt, q_nxt};
                    finalizado <= 1'b1;
                end
            end else if (div0_pend) begin
                // q_sr still holds the untouched dividend on the divide-by-zero path
                cociente   <= {q_sr, {WIDTH{1'b1}}};
                finalizado <= 1'b1;
                div0_pend  <= 1'b0;
            end
        end
    end

endmodule
